mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port among 4 requesters (0 fetch, 1 ld/st, 2 DMA, 3 debug); optional ARB_LOCK_EN adds a lock input for back-to-back grants.
// Latency: grant one cycle after REQ is sampled in IDLE, ACK pulse ACCESS_CYCLES+2 cycles after sampling.
// Backpressure: REQ is level-held until ACK; REQ is ignored while BUSY, so losers simply wait for a later IDLE cycle.
module mem_port_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef ARB_LOCK_EN
    input  logic [3:0] lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       mem_start,
    output logic [3:0] ack,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GRANT = 2'b01,
        S_WAIT  = 2'b10,
        S_ACK   = 2'b11
    } state_t;

    // A latency of zero is treated as one cycle in WAIT.
    localparam int              LOAD_I   = (ACCESS_CYCLES > 1) ? ACCESS_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);

    state_t           state, state_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       sel_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       win;
    logic             win_vld;
    logic [1:0]       scan_idx;
    logic             hold;

    // First requester found scanning from ptr upward, wrapping mod 4.
    always_comb begin
        win      = 2'd0;
        win_vld  = 1'b0;
        scan_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr + 2'(i);
            if (!win_vld && req[scan_idx]) begin
                win     = scan_idx;
                win_vld = 1'b1;
            end
        end
    end

`ifdef ARB_LOCK_EN
    assign hold = lock[sel] && req[sel];
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_nxt   = 4'b0001 << win;
                    sel_nxt   = win;
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_ACK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_ACK: begin
                // A locked winner re-enters GRANT with pointer and grant untouched.
                if (hold) begin
                    state_nxt = S_GRANT;
                end else begin
                    ptr_nxt   = sel + 2'd1;
                    gnt_nxt   = 4'b0000;
                    sel_nxt   = 2'd0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign mem_start = (state == S_GRANT);
    assign ack       = (state == S_ACK) ? gnt : 4'b0000;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants, a negedge monitor checks starts and acks.
module tb_mem_port_arbiter;
    localparam int ACC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
`ifdef ARB_LOCK_EN
    logic [3:0] lock = 4'b0000;
`endif
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       mem_start;
    logic [3:0] ack;
    logic       busy;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] oh;
        logic [1:0] idx;
        int         start_cyc;
        int         ack_cyc;
    } exp_t;
    exp_t sb[$];

    mem_port_arbiter #(.ACCESS_CYCLES(ACC), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .sel       (sel),
        .mem_start (mem_start),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    function automatic void push_exp(input logic [1:0] idx, input int start);
        exp_t e;
        e.oh        = 4'b0001 << idx;
        e.idx       = idx;
        e.start_cyc = start;
        e.ack_cyc   = start + ACC + 1;
        sb.push_back(e);
    endfunction

    // Monitor: every start and every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_start) begin
                if (sb.size() == 0) begin
                    fail_now("start_unexpected");
                end else begin
                    check("start_gnt", {28'd0, gnt}, {28'd0, sb[0].oh});
                    check("start_sel", {30'd0, sel}, {30'd0, sb[0].idx});
                    check("start_cyc", cyc, sb[0].start_cyc);
                end
            end
            if (ack != 4'b0000) begin
                if (sb.size() == 0) begin
                    fail_now("ack_unexpected");
                end else begin
                    check("ack_val", {28'd0, ack}, {28'd0, sb[0].oh});
                    check("ack_in_gnt", {28'd0, ack & ~gnt}, 32'd0);
                    check("ack_cyc", cyc, sb[0].ack_cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic wait_acks(input int want, input bit gap_chk);
        int n;
        n = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ack != 4'b0000) begin
                n++;
                if (n == want) break;
                if (gap_chk) begin
                    @(negedge clk);
                    check("gap_busy", {31'd0, busy}, 32'd0);
                    check("gap_gnt", {28'd0, gnt}, 32'd0);
                end
            end
        end
        if (n != want) fail_now("ack_timeout");
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (mem_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("start_timeout");
    endtask

    task automatic run_one(input logic [3:0] r, input logic [1:0] idx);
        @(negedge clk);
        push_exp(idx, cyc + 1);
        req = r;
        wait_acks(1, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int k;
        // Reset values
        #3 rst = 1'b1;
        #1;
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_sel", {30'd0, sel}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_start", {31'd0, mem_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single request from requester 0
        run_one(4'b0001, 2'd0);

        // Back to reset so the pointer starts at 0, then all four held
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        k = cyc + 1;
        for (int i = 0; i < 5; i++) push_exp(2'(i % 4), k + i * (ACC + 3));
        req = 4'b1111;
        wait_acks(5, 1'b1);
        req = 4'b0000;
        @(negedge clk);

        // Pointer at 2 with 0 and 1 requesting: 0 wins, then 1
        run_one(4'b0010, 2'd1);
        @(negedge clk);
        k = cyc + 1;
        push_exp(2'd0, k);
        push_exp(2'd1, k + ACC + 3);
        req = 4'b0011;
        wait_acks(2, 1'b0);
        req = 4'b0000;
        @(negedge clk);

        // Winner drops its request during WAIT: ack still arrives, no re-grant
        @(negedge clk);
        push_exp(2'd1, cyc + 1);
        req = 4'b0010;
        wait_start();
        @(negedge clk);
        req = 4'b0000;
        wait_acks(1, 1'b0);
        repeat (6) @(negedge clk);
        check("no_regrant", {31'd0, busy}, 32'd0);

        // Asynchronous reset during WAIT abandons the access
        @(negedge clk);
        push_exp(2'd2, cyc + 1);
        req = 4'b0100;
        wait_start();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_gnt", {28'd0, gnt}, 32'd0);
        check("arst_sel", {30'd0, sel}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ack", {28'd0, ack}, 32'd0);
        sb.delete();
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        // Pointer must be 0 again: 0 beats 3
        run_one(4'b1001, 2'd0);
        run_one(4'b0100, 2'd2);

`ifdef ARB_LOCK_EN
        // Locked requester 1 gets two back-to-back accesses, then requester 0
        run_one(4'b0001, 2'd0);
        @(negedge clk);
        k = cyc + 1;
        push_exp(2'd1, k);
        push_exp(2'd1, k + ACC + 2);
        push_exp(2'd0, k + 2 * ACC + 5);
        lock = 4'b0010;
        req  = 4'b0011;
        wait_acks(1, 1'b0);
        @(negedge clk);
        check("lock_busy", {31'd0, busy}, 32'd1);
        lock = 4'b0000;
        wait_acks(1, 1'b0);
        req = 4'b0001;
        wait_acks(1, 1'b0);
        req = 4'b0000;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
